note_scheduler: RTL and testbench

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/audio_pkg.sv | 32 +++
 rtl/note_scheduler_if.sv | 22 ++
 rtl/cmd_fifo.sv | 72 +++++++
 rtl/note_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_note_scheduler.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the note scheduler slice.
// Holds the MIDI status codes handled by the parser, the queued command
// record, the parser state encoding and the velocity-to-gain helper.
package audio_pkg;

    // Upper nibble of the MIDI status bytes that are acted upon.
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] NOTE_OFF = 4'h8;

    // Command kind stored in the FIFO.
    localparam logic KIND_OFF = 1'b0;
    localparam logic KIND_ON  = 1'b1;

    // One fully parsed command waiting for the next audio sample.
    typedef struct packed {
        logic       kind;
        logic [6:0] note;
        logic [6:0] vel;
    } cmd_t;

    // Parser states.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ON_NOTE  = 2'd1;
    localparam logic [1:0] ST_ON_VEL   = 2'd2;
    localparam logic [1:0] ST_OFF_NOTE = 2'd3;

    // 7-bit velocity to 8-bit gain: replicating the MSB maps 0x7F to 0xFF.
    function automatic logic [7:0] vel_to_gain(input logic [6:0] vel);
        return {vel, vel[6]};
    endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// Byte-stream handshake between the UART receiver and the note scheduler.
//   rx_valid : a received byte is available
//   rx_byte  : the received byte
//   rx_ready : the scheduler can accept a byte (transfer on valid && ready)
// master = UART side, slave = scheduler side.
interface note_scheduler_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ready;

    modport master (
        output rx_valid,
        output rx_byte,
        input  rx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_byte,
        output rx_ready
    );
endinterface

// File: rtl/cmd_fifo.sv
// Command FIFO between the MIDI parser and the sample-synchronous apply logic.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : write push_data (ignored when full)
//   push_data   : command to enqueue
//   pop         : discard the head entry (ignored when empty)
//   pop_data    : current head entry (valid while !empty)
//   full, empty : occupancy flags derived from registered state only
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module cmd_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

    cmd_t            mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == (AW + 1)'(0));
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage array and pointers; pointers wrap modulo DEPTH by overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// MIDI note scheduler: parses note-on / note-off messages from a UART byte
// stream, queues completed commands and applies one per audio sample strobe
// to the DDS note / gain / gate outputs.
// Ports:
//   clk, rst_n     : system clock, asynchronous active-low reset
//   rx             : byte handshake (rx_valid, rx_byte in; rx_ready out)
//   sample_strobe  : one pulse per audio sample; at most one command applied
//   change_note    : one-cycle pulse telling the DDS to load note
//   note, gain     : current note number and amplitude
//   gate           : a note is sounding
//   leds           : low nibble of note while sounding, else 0
//   timeout_err    : one-cycle pulse when a partial command is dropped
module note_scheduler
    import audio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 245760,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    note_scheduler_if.slave  rx,
    input  logic             sample_strobe,
    output logic             change_note,
    output logic [6:0]       note,
    output logic [7:0]       gain,
    output logic             gate,
    output logic [3:0]       leds,
    output logic             timeout_err
);
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Parser state
    logic [1:0]    state_r,    state_nx_s;
    logic [6:0]    note_lat_r, note_lat_nx_s;
    logic [TW-1:0] cnt_r,      cnt_nx_s;
    logic          to_err_r,   to_err_nx_s;
    logic          accept_s;
    logic          push_s;
    cmd_t          push_cmd_s;

    // FIFO side
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          pop_s;
    cmd_t          pop_cmd_s;

    // Output registers
    logic [6:0]    note_r,  note_nx_s;
    logic [7:0]    gain_r,  gain_nx_s;
    logic          gate_r,  gate_nx_s;
    logic          chg_r,   chg_nx_s;
    logic [3:0]    leds_r;

    assign rx.rx_ready = !fifo_full_s;
    assign accept_s    = rx.rx_valid && !fifo_full_s;
    // The FIFO is sampled before this cycle's push, so a same-cycle push
    // into an empty FIFO waits for the next strobe.
    assign pop_s       = sample_strobe && !fifo_empty_s;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_cmd_s),
        .pop       (pop_s),
        .pop_data  (pop_cmd_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Parser next-state, command assembly and inactivity timeout.
    always_comb begin
        state_nx_s    = state_r;
        note_lat_nx_s = note_lat_r;
        cnt_nx_s      = cnt_r;
        to_err_nx_s   = 1'b0;
        push_s        = 1'b0;
        push_cmd_s    = '0;
        if (accept_s) begin
            cnt_nx_s = '0;
            if (rx.rx_byte[7]) begin
                // Status byte restarts parsing; channel nibble is ignored.
                case (rx.rx_byte[7:4])
                    NOTE_ON:  state_nx_s = ST_ON_NOTE;
                    NOTE_OFF: state_nx_s = ST_OFF_NOTE;
                    default:  state_nx_s = ST_IDLE;
                endcase
            end else begin
                case (state_r)
                    ST_ON_NOTE: begin
                        note_lat_nx_s = rx.rx_byte[6:0];
                        state_nx_s    = ST_ON_VEL;
                    end
                    ST_ON_VEL: begin
                        push_s          = 1'b1;
                        // Velocity 0 is the running-status form of note-off.
                        push_cmd_s.kind = (rx.rx_byte[6:0] != 7'd0) ? KIND_ON : KIND_OFF;
                        push_cmd_s.note = note_lat_r;
                        push_cmd_s.vel  = rx.rx_byte[6:0];
                        state_nx_s      = ST_IDLE;
                    end
                    ST_OFF_NOTE: begin
                        push_s          = 1'b1;
                        push_cmd_s.kind = KIND_OFF;
                        push_cmd_s.note = rx.rx_byte[6:0];
                        push_cmd_s.vel  = 7'd0;
                        state_nx_s      = ST_IDLE;
                    end
                    default: begin
                        state_nx_s = ST_IDLE;
                    end
                endcase
            end
        end else if (state_r != ST_IDLE) begin
            if (cnt_r == TO_LAST) begin
                state_nx_s  = ST_IDLE;
                cnt_nx_s    = '0;
                to_err_nx_s = 1'b1;
            end else begin
                cnt_nx_s = cnt_r + TW'(1);
            end
        end else begin
            cnt_nx_s = '0;
        end
    end

    // Parser registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            note_lat_r <= 7'd0;
            cnt_r      <= '0;
            to_err_r   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            note_lat_r <= note_lat_nx_s;
            cnt_r      <= cnt_nx_s;
            to_err_r   <= to_err_nx_s;
        end
    end

    // Apply the popped command to the voice outputs.
    always_comb begin
        note_nx_s = note_r;
        gain_nx_s = gain_r;
        gate_nx_s = gate_r;
        chg_nx_s  = 1'b0;
        if (pop_s) begin
            if (pop_cmd_s.kind == KIND_ON) begin
                note_nx_s = pop_cmd_s.note;
                gain_nx_s = vel_to_gain(pop_cmd_s.vel);
                gate_nx_s = 1'b1;
                chg_nx_s  = 1'b1;
            end else if (gate_r && (pop_cmd_s.note == note_r)) begin
                // Note-off releases only the sounding note; note is held.
                gain_nx_s = 8'd0;
                gate_nx_s = 1'b0;
            end else begin
                gate_nx_s = gate_r;
            end
        end else begin
            chg_nx_s = 1'b0;
        end
    end

    // Voice output registers; leds follow the next-state gate/note.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_r <= 7'd0;
            gain_r <= 8'd0;
            gate_r <= 1'b0;
            chg_r  <= 1'b0;
            leds_r <= 4'd0;
        end else begin
            note_r <= note_nx_s;
            gain_r <= gain_nx_s;
            gate_r <= gate_nx_s;
            chg_r  <= chg_nx_s;
            leds_r <= gate_nx_s ? note_nx_s[3:0] : 4'd0;
        end
    end

    assign note        = note_r;
    assign gain        = gain_r;
    assign gate        = gate_r;
    assign change_note = chg_r;
    assign leds        = leds_r;
    assign timeout_err = to_err_r;

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler: directed scenarios plus random
// byte/strobe traffic, every cycle compared against a behavioural model.
module tb_note_scheduler;
    localparam int TO    = 40;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_strobe = 1'b0;
    logic       change_note;
    logic [6:0] note;
    logic [7:0] gain;
    logic       gate;
    logic [3:0] leds;
    logic       timeout_err;

    note_scheduler_if rx_if ();

    note_scheduler #(
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx_if),
        .sample_strobe (sample_strobe),
        .change_note   (change_note),
        .note          (note),
        .gain          (gain),
        .gate          (gate),
        .leds          (leds),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          chg_seen = 0;
    int          to_seen  = 0;

    // ---------------- reference model ----------------
    typedef struct { bit on; int n; int v; } mcmd_t;
    mcmd_t mq[$];
    int    m_mode;          // 0: nothing pending, 1: note-on message, 2: note-off message
    int    m_data[$];       // data bytes collected for the pending message
    int    m_idle;
    int    m_note, m_gain;
    bit    m_gate, m_chg, m_to;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_data.delete();
        m_mode = 0; m_idle = 0;
        m_note = 0; m_gain = 0; m_gate = 0; m_chg = 0; m_to = 0;
    endtask

    task automatic model_push(input bit on, input int n, input int v);
        mcmd_t c;
        c.on = on; c.n = n; c.v = v;
        mq.push_back(c);
    endtask

    // One clock edge of behaviour: apply queued command, then parse the byte.
    task automatic model_step(input bit acc, input int b, input bit s);
        mcmd_t c;
        m_chg = 0; m_to = 0;
        if (s && mq.size() > 0) begin
            c = mq.pop_front();
            if (c.on) begin
                m_note = c.n; m_gain = c.v * 2 + (c.v >= 64 ? 1 : 0);
                m_gate = 1; m_chg = 1;
            end else if (m_gate && c.n == m_note) begin
                m_gate = 0; m_gain = 0;
            end
        end
        if (acc) begin
            m_idle = 0;
            if (b >= 128) begin
                m_data.delete();
                m_mode = ((b / 16) == 9) ? 1 : ((b / 16) == 8) ? 2 : 0;
            end else if (m_mode != 0) begin
                m_data.push_back(b);
                if (m_mode == 2) begin
                    model_push(0, b, 0);
                    m_mode = 0; m_data.delete();
                end else if (m_data.size() == 2) begin
                    model_push(m_data[1] != 0, m_data[0], m_data[1]);
                    m_mode = 0; m_data.delete();
                end
            end
        end else if (m_mode != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_mode = 0; m_data.delete(); m_idle = 0; m_to = 1;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("note", 32'(note), 32'(m_note));
        check_val("gain", 32'(gain), 32'(m_gain));
        check_val("gate", 32'(gate), 32'(m_gate));
        check_val("change_note", 32'(change_note), 32'(m_chg));
        check_val("leds", 32'(leds), m_gate ? 32'(m_note % 16) : 32'd0);
        check_val("timeout_err", 32'(timeout_err), 32'(m_to));
    endtask

    // One clock cycle of stimulus with full output comparison.
    task automatic cyc(input bit v, input logic [7:0] b, input bit s, output bit acc);
        @(negedge clk);
        rx_if.rx_valid = v;
        rx_if.rx_byte  = b;
        sample_strobe  = s;
        #1;
        check_val("rx_ready", 32'(rx_if.rx_ready), 32'(mq.size() < DEPTH));
        acc = v && (mq.size() < DEPTH);
        @(posedge clk);
        model_step(acc, int'(b), s);
        #1;
        check_outputs();
        if (change_note === 1'b1) chg_seen++;
        if (timeout_err === 1'b1) to_seen++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, a);
    endtask

    task automatic strobe();
        bit a;
        cyc(1'b0, 8'h00, 1'b1, a);
    endtask

    // Offer a byte until accepted, bounded.
    task automatic send(input logic [7:0] b);
        bit a;
        int k;
        a = 0; k = 0;
        while (!a && k < 20) begin
            cyc(1'b1, b, 1'b0, a);
            k++;
        end
        if (!a) check_val("send_accept", 32'd0, 32'd1);
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send(b0); send(b1); send(b2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_byte  = 8'h00;
        sample_strobe  = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check_val("rx_ready_rst", 32'(rx_if.rx_ready), 32'd1);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int r;
        logic [7:0] b;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_byte  = 8'h00;
        model_reset();
        do_reset();
        idle(2);

        // Note-on 0x45 full velocity
        send3(8'h90, 8'h45, 8'h7F);
        strobe();
        check_val("r036_note", 32'(note), 32'h45);
        check_val("r036_gain", 32'(gain), 32'hFF);
        check_val("r036_leds", 32'(leds), 32'h5);
        idle(1);

        // Off for a different note has no effect, matching note releases
        send(8'h80); send(8'h44); strobe();
        check_val("r037_gate_hold", 32'(gate), 32'd1);
        send(8'h80); send(8'h45); strobe();
        check_val("r037_gate", 32'(gate), 32'd0);
        check_val("r037_note", 32'(note), 32'h45);

        // Partial command times out exactly once
        to_seen = 0;
        send(8'h90); send(8'h40);
        idle(TO + 5);
        check_val("r038_to_count", 32'(to_seen), 32'd1);
        send(8'h30); strobe();
        check_val("r038_ready", 32'(rx_if.rx_ready), 32'd1);

        // Back-pressure with five note-ons
        chg_seen = 0;
        send3(8'h90, 8'h41, 8'h10);
        send3(8'h91, 8'h42, 8'h20);
        send3(8'h92, 8'h43, 8'h30);
        send3(8'h93, 8'h44, 8'h40);
        @(negedge clk); #1;
        check_val("r039_full", 32'(rx_if.rx_ready), 32'd0);
        strobe();
        send3(8'h94, 8'h46, 8'h50);
        for (int i = 0; i < 4; i++) strobe();
        check_val("r039_chg", 32'(chg_seen), 32'd5);
        check_val("r039_last", 32'(note), 32'h46);

        // Status byte aborts; velocity-0 note-on acts as note-off
        send3(8'h90, 8'h3C, 8'h50); strobe();
        send(8'h90); send(8'h40); send(8'hC0); send(8'h3C); send(8'h00);
        strobe();
        check_val("r040_gate_on", 32'(gate), 32'd1);
        chg_seen = 0;
        send3(8'h90, 8'h3C, 8'h00); strobe();
        check_val("r040_gate_off", 32'(gate), 32'd0);
        check_val("r040_no_chg", 32'(chg_seen), 32'd0);

        // Reset with a partial command and two queued entries
        send3(8'h90, 8'h50, 8'h11);
        send3(8'h90, 8'h51, 8'h22);
        send(8'h90); send(8'h40);
        do_reset();
        for (int i = 0; i < 3; i++) strobe();
        check_val("r041_gate", 32'(gate), 32'd0);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    b = 8'h90 | 8'($urandom_range(0, 15));
                2:       b = 8'h80 | 8'($urandom_range(0, 15));
                3:       b = 8'hA0 | 8'($urandom_range(0, 95));
                4:       b = 8'h00;
                default: b = 8'h40 + 8'($urandom_range(0, 3));
            endcase
            cyc($urandom_range(0, 9) < 6, b, $urandom_range(0, 3) == 0, a);
            if ($urandom_range(0, 299) == 0) idle(TO + 2);
            if ($urandom_range(0, 799) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
